// File: rtl/mtr_drv_if.sv
// Signal bundle between the balance controller and the motor drive stage.
// There is no valid/ready handshake: the speed commands and enable are
// level-sampled on every rising clock edge, and the gate drives and period
// pulse are registered outputs. The sampled values matter only at the
// period boundary.
interface mtr_drv_if;
  logic signed [11:0] lft_spd;
  logic signed [11:0] rght_spd;
  logic               en;
  logic               lft_hi;
  logic               lft_lo;
  logic               rght_hi;
  logic               rght_lo;
  logic               prd_strt;

  // The controller drives the commands and observes the gate drives.
  modport master (
    output lft_spd, rght_spd, en,
    input  lft_hi, lft_lo, rght_hi, rght_lo, prd_strt
  );

  // The drive stage consumes the commands and produces the gate drives.
  modport slave (
    input  lft_spd, rght_spd, en,
    output lft_hi, lft_lo, rght_hi, rght_lo, prd_strt
  );
endinterface

// File: rtl/mtr_drv.sv
// Motor drive stage: two edge-aligned PWM channels (left = 0, right = 1)
// that share one free-running 4096-cycle period counter. Duty is
// double-buffered to the period boundary. Each channel feeds an H-bridge
// through a non-overlap deadtime stage.
module mtr_drv #(
  parameter int unsigned DEADTIME = 32
) (
  input  logic      clk,
  input  logic      rst,
  mtr_drv_if.slave  bus
);

  localparam logic [11:0] CNT_LAST  = 12'hFFF;
  localparam logic [11:0] DUTY_RST  = 12'h800;
  localparam logic [7:0]  DT_LIMIT  = 8'(DEADTIME);

  logic [11:0]       cnt_q, cnt_d;
  logic              prd_q, prd_d;
  logic [1:0][11:0]  duty_q, duty_d;
  logic [1:0]        pwm_q, pwm_d;
  logic [1:0]        prev_q, prev_d;
  logic [1:0][7:0]   dt_q, dt_d;
  logic [1:0]        hi_q, hi_d;
  logic [1:0]        lo_q, lo_d;
  logic [1:0][11:0]  spd;

  assign spd[0] = bus.lft_spd;
  assign spd[1] = bus.rght_spd;

  // Period counter, period pulse, boundary-buffered duty, and PWM compare.
  always_comb begin
    cnt_d  = cnt_q + 12'd1;
    prd_d  = (cnt_q == CNT_LAST);
    duty_d = duty_q;
    pwm_d  = '0;
    for (int i = 0; i < 2; i++) begin
      // Signed speed to unsigned duty: invert the MSB (adds 2048 mod 4096).
      if (cnt_q == CNT_LAST) begin
        duty_d[i] = {~spd[i][11], spd[i][10:0]};
      end
      pwm_d[i] = (cnt_q < duty_q[i]);
    end
  end

  // Deadtime stage. A gate is driven only after pwm has held steady, with
  // the bridge enabled, until dt has counted up to DEADTIME. hi and lo are
  // then complements of one bit, so they can never be high together.
  always_comb begin
    prev_d = pwm_q;
    dt_d   = dt_q;
    hi_d   = '0;
    lo_d   = '0;
    for (int i = 0; i < 2; i++) begin
      if (!bus.en) begin
        dt_d[i] = 8'd0;
      end else if (pwm_q[i] != prev_q[i]) begin
        dt_d[i] = 8'd0;
      end else if (dt_q[i] != DT_LIMIT) begin
        dt_d[i] = dt_q[i] + 8'd1;
      end else begin
        hi_d[i] = pwm_q[i];
        lo_d[i] = ~pwm_q[i];
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      prd_q  <= 1'b0;
      duty_q <= {DUTY_RST, DUTY_RST};
      pwm_q  <= '0;
      prev_q <= '0;
      dt_q   <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
    end else begin
      cnt_q  <= cnt_d;
      prd_q  <= prd_d;
      duty_q <= duty_d;
      pwm_q  <= pwm_d;
      prev_q <= prev_d;
      dt_q   <= dt_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
    end
  end

  assign bus.lft_hi   = hi_q[0];
  assign bus.lft_lo   = lo_q[0];
  assign bus.rght_hi  = hi_q[1];
  assign bus.rght_lo  = lo_q[1];
  assign bus.prd_strt = prd_q;

endmodule

// File: tb/tb_mtr_drv.sv
// Bench for mtr_drv: directed scenarios plus random speed/enable segments.
// Every cycle is scored against a behavioural model.
module tb_mtr_drv;

  localparam int DT  = 32;
  localparam int PRD = 4096;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mtr_drv_if bus();

  mtr_drv #(.DEADTIME(DT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- checking ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Duty is the speed offset by 2048 and latched at the period's last cycle.
  // pwm is "count below duty", registered. A gate drives the current pwm
  // level once the channel has seen DT+1 consecutive enabled edges with no
  // pwm change.
  int       m_cnt;
  int       m_duty [2];
  int       m_run  [2];
  int       spd_v  [2];
  bit       m_pwm  [2];
  bit       m_prev [2];
  bit       m_hi   [2];
  bit       m_lo   [2];
  bit       m_nxt;
  bit       m_prd;
  bit       m_valid = 1'b0;
  logic [4:0] exp_q[$];

  always @(posedge clk) begin
    spd_v[0] = int'($signed(bus.lft_spd));
    spd_v[1] = int'($signed(bus.rght_spd));
    if (rst) begin
      m_cnt   = 0;
      m_prd   = 1'b0;
      m_valid = 1'b1;
      for (int c = 0; c < 2; c++) begin
        m_duty[c] = 2048;
        m_pwm[c]  = 1'b0;
        m_prev[c] = 1'b0;
        m_run[c]  = 0;
        m_hi[c]   = 1'b0;
        m_lo[c]   = 1'b0;
      end
    end else begin
      for (int c = 0; c < 2; c++) begin
        if (bus.en && (m_pwm[c] == m_prev[c]))
          m_run[c] = (m_run[c] < 1000) ? m_run[c] + 1 : m_run[c];
        else
          m_run[c] = 0;
        m_hi[c]   = (m_run[c] > DT) &&  m_pwm[c];
        m_lo[c]   = (m_run[c] > DT) && !m_pwm[c];
        m_nxt     = (m_cnt < m_duty[c]);
        m_prev[c] = m_pwm[c];
        m_pwm[c]  = m_nxt;
        if (m_cnt == PRD - 1) m_duty[c] = spd_v[c] + 2048;
      end
      m_prd = (m_cnt == PRD - 1);
      m_cnt = (m_cnt + 1) % PRD;
    end
    if (m_valid) exp_q.push_back({m_prd, m_lo[1], m_hi[1], m_lo[0], m_hi[0]});
  end

  // Scoreboard: compare every cycle on the falling edge.
  logic [4:0] sb_exp, sb_obs;
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      sb_exp = exp_q.pop_front();
      sb_obs = {bus.prd_strt, bus.rght_lo, bus.rght_hi, bus.lft_lo, bus.lft_hi};
      chk("model", 32'(sb_obs), 32'(sb_exp));
      chk("no_overlap", 32'({bus.lft_hi & bus.lft_lo, bus.rght_hi & bus.rght_lo}), 32'd0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Returns how many falling edges passed before prd_strt was seen (-1 if never).
  task automatic wait_prd(output int n);
    n = -1;
    for (int i = 1; i <= PRD + 16; i++) begin
      @(negedge clk);
      if (bus.prd_strt) begin
        n = i;
        break;
      end
    end
    chk("prd_strt_seen", 32'(n > 0), 32'd1);
  endtask

  // Counts gate activity over one period, starting at the current falling
  // edge (count = 0) and ending at the next count = 0. Optionally changes
  // lft_spd at a given count inside the period.
  task automatic measure(input int chg_at, input logic [11:0] chg_val,
                         output int lh, output int ll, output int rh,
                         output int rl, output int lgap);
    lh = 0; ll = 0; rh = 0; rl = 0; lgap = 0;
    for (int i = 0; i < PRD; i++) begin
      if (i == chg_at) bus.lft_spd = chg_val;
      lh += int'(bus.lft_hi);
      ll += int'(bus.lft_lo);
      rh += int'(bus.rght_hi);
      rl += int'(bus.rght_lo);
      if (!bus.lft_hi && !bus.lft_lo) lgap++;
      @(negedge clk);
    end
  endtask

  function automatic logic [11:0] pick_spd();
    logic [11:0] v;
    case ($urandom_range(0, 3))
      0:       v = 12'h800 + 12'($urandom_range(0, 40));
      1:       v = 12'h7FF - 12'($urandom_range(0, 40));
      default: v = 12'($urandom_range(0, 4095));
    endcase
    return v;
  endfunction

  // ---------------- stimulus ----------------
  int n, lh, ll, rh, rl, lgap;

  initial begin
    rst = 1'b1;
    bus.en = 1'b0;
    bus.lft_spd = '0;
    bus.rght_spd = '0;
    cyc(3);
    chk("rst_outs", 32'({bus.prd_strt, bus.rght_lo, bus.rght_hi, bus.lft_lo, bus.lft_hi}), 32'd0);

    // Zero speed left, full reverse right.
    bus.lft_spd  = 12'sd0;
    bus.rght_spd = 12'sh800;
    bus.en = 1'b1;
    rst = 1'b0;
    wait_prd(n);
    chk("first_wrap", 32'(n), 32'd4096);
    measure(-1, 12'd0, lh, ll, rh, rl, lgap);
    measure(-1, 12'd0, lh, ll, rh, rl, lgap);
    chk("zero_lh", 32'(lh), 32'd2015);
    chk("zero_ll", 32'(ll), 32'd2015);
    chk("zero_gap", 32'(lgap), 32'd66);
    chk("rev_rh", 32'(rh), 32'd0);
    chk("rev_rl", 32'(rl), 32'd4096);

    // Full forward left.
    bus.lft_spd = 12'sh7FF;
    measure(-1, 12'd0, lh, ll, rh, rl, lgap);
    measure(-1, 12'd0, lh, ll, rh, rl, lgap);
    measure(-1, 12'd0, lh, ll, rh, rl, lgap);
    chk("fwd_lh", 32'(lh), 32'd4062);
    chk("fwd_ll", 32'(ll), 32'd0);
    chk("fwd_rl", 32'(rl), 32'd4096);

    // Mid-period update: 0 -> +1024 at count 1000.
    bus.lft_spd = 12'sd0;
    measure(-1, 12'd0, lh, ll, rh, rl, lgap);
    measure(-1, 12'd0, lh, ll, rh, rl, lgap);
    measure(1000, 12'd1024, lh, ll, rh, rl, lgap);
    chk("mid_cur_lh", 32'(lh), 32'd2015);
    measure(-1, 12'd0, lh, ll, rh, rl, lgap);
    chk("mid_next_lh", 32'(lh), 32'd3039);

    // Enable drop at count 500, raise at count 900.
    cyc(500);
    chk("en_hi_before", 32'(bus.lft_hi), 32'd1);
    bus.en = 1'b0;
    cyc(1);
    chk("en_drop", 32'({bus.lft_hi, bus.lft_lo, bus.rght_hi, bus.rght_lo}), 32'd0);
    cyc(399);
    bus.en = 1'b1;
    n = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      n++;
      if (bus.lft_hi) break;
    end
    chk("en_recover", 32'(n), 32'd33);
    chk("en_recover_rlo", 32'(bus.rght_lo), 32'd1);

    // One-cycle reset at count 3000 with lft_spd = +500.
    bus.lft_spd = 12'sd500;
    wait_prd(n);
    cyc(3000);
    rst = 1'b1;
    cyc(1);
    chk("rst_mid_outs", 32'({bus.prd_strt, bus.rght_lo, bus.rght_hi, bus.lft_lo, bus.lft_hi}), 32'd0);
    rst = 1'b0;
    measure(-1, 12'd0, lh, ll, rh, rl, lgap);
    chk("rst_duty_lh", 32'(lh), 32'd2015);
    chk("rst_wrap_prd", 32'(bus.prd_strt), 32'd1);
    measure(-1, 12'd0, lh, ll, rh, rl, lgap);
    chk("rst_next_lh", 32'(lh), 32'd2515);

    // Random speed / enable segments, scored by the model.
    for (int s = 0; s < 10; s++) begin
      bus.lft_spd  = pick_spd();
      bus.rght_spd = pick_spd();
      bus.en = ($urandom_range(0, 3) != 0);
      cyc($urandom_range(50, 1500));
    end
    bus.en = 1'b1;
    cyc(2 * (DT + 2));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Hard stop in case anything above stalls.
  initial begin
    #(10 * 100000);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1, "watchdog expired");
  end

endmodule
